// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants, controller state type and message-schedule
// helpers for the SHA-256 round sequencer.
package sha256_pkg;

    localparam int unsigned WORDS  = 16;
    localparam int unsigned ROUNDS = 64;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRound,
        StFinal
    } state_e;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // sigma0: ror7 ^ ror18 ^ shr3
    function automatic logic [31:0] sigma0_w(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1: ror17 ^ ror19 ^ shr10
    function automatic logic [31:0] sigma1_w(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: 16-word circular message buffer. Loaded from the input
// stream, then expands W[t] in place, writing each expanded word back to
// slot t mod 16 on the cycle it is presented.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load_en,
    input  logic [3:0]  i_load_idx,
    input  logic [31:0] i_word,
    input  logic        i_round_en,
    input  logic [5:0]  i_t,
    output logic [31:0] o_w
);

    logic [31:0] r_buf [WORDS];

    logic [3:0]  w_idx;
    logic [3:0]  w_idx_m2;
    logic [3:0]  w_idx_m7;
    logic [3:0]  w_idx_m15;
    logic        w_expand;
    logic [31:0] w_exp;

    // Index arithmetic wraps at 4 bits, which is exactly mod 16.
    assign w_idx     = i_t[3:0];
    assign w_idx_m2  = w_idx - 4'd2;
    assign w_idx_m7  = w_idx - 4'd7;
    assign w_idx_m15 = w_idx - 4'd15;
    assign w_expand  = |i_t[5:4];

    // Slot t mod 16 still holds W[t-16] when W[t] is formed.
    assign w_exp = sigma1_w(r_buf[w_idx_m2]) + r_buf[w_idx_m7]
                 + sigma0_w(r_buf[w_idx_m15]) + r_buf[w_idx];

    assign o_w = w_expand ? w_exp : r_buf[w_idx];

    // Buffer write: stream words while loading, expanded words during rounds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                r_buf[i] <= '0;
            end
        end else if (i_load_en) begin
            r_buf[i_load_idx] <= i_word;
        end else if (i_round_en && w_expand) begin
            r_buf[w_idx] <= w_exp;
        end
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: accepts a 16-word chunk over valid/ready, then sequences
// the compression core through LOAD, 63 ROUND cycles and FINAL.
// Build option: define SHA256_CTRL_BYTESWAP_EN to byte-reverse incoming words
// (little-endian feeders); otherwise words are stored unchanged.
module sha256_round_ctrl
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    input  logic [31:0] i_s_data,
    input  logic        i_s_last,
    output logic [31:0] o_w_out,
    output logic [31:0] o_k_out,
    output logic        o_compress_start,
    output logic        o_update_hash,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_hash_valid
);

    state_e      r_state;
    logic [3:0]  r_count;
    logic [5:0]  r_t;
    logic        r_last;
    logic        r_compress_start;
    logic        r_update_hash;
    logic        r_done;
    logic        r_hash_valid;

    logic        w_hs;
    logic        w_round_en;
    logic [31:0] w_word_in;
    logic [31:0] w_sched;

`ifdef SHA256_CTRL_BYTESWAP_EN
    assign w_word_in = {i_s_data[7:0], i_s_data[15:8], i_s_data[23:16], i_s_data[31:24]};
`else
    assign w_word_in = i_s_data;
`endif

    assign o_s_ready  = (r_state == StIdle);
    assign o_busy     = (r_state != StIdle);
    assign w_hs       = i_s_valid & o_s_ready;
    assign w_round_en = (r_state == StRound);

    // Round word/constant are don't-care in FINAL and forced to zero there.
    assign o_w_out = (r_state == StFinal) ? 32'h0 : w_sched;
    assign o_k_out = (r_state == StFinal) ? 32'h0 : K[r_t];

    assign o_compress_start = r_compress_start;
    assign o_update_hash    = r_update_hash;
    assign o_done           = r_done;
    assign o_hash_valid     = r_hash_valid;

    sha256_msg_schedule u_sched (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load_en  (w_hs),
        .i_load_idx (r_count),
        .i_word     (w_word_in),
        .i_round_en (w_round_en),
        .i_t        (r_t),
        .o_w        (w_sched)
    );

    // Controller FSM with word count, round index and registered core strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= StIdle;
            r_count          <= '0;
            r_t              <= '0;
            r_last           <= 1'b0;
            r_compress_start <= 1'b0;
            r_update_hash    <= 1'b0;
            r_done           <= 1'b0;
            r_hash_valid     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_compress_start <= 1'b0;
                    r_update_hash    <= 1'b0;
                    if (w_hs) begin
                        // A new chunk invalidates the previously reported digest.
                        if (r_count == 4'd0) begin
                            r_hash_valid <= 1'b0;
                        end
                        if (r_count == 4'(WORDS - 1)) begin
                            r_last  <= i_s_last;
                            r_count <= '0;
                            r_t     <= '0;
                            r_state <= StLoad;
                        end else begin
                            r_count <= r_count + 4'd1;
                        end
                    end
                end
                StLoad: begin
                    r_t              <= 6'd1;
                    r_compress_start <= 1'b1;
                    r_state          <= StRound;
                end
                StRound: begin
                    if (r_t == 6'(ROUNDS - 1)) begin
                        r_update_hash <= 1'b1;
                        r_state       <= StFinal;
                    end else begin
                        r_t <= r_t + 6'd1;
                    end
                end
                StFinal: begin
                    r_compress_start <= 1'b0;
                    r_update_hash    <= 1'b0;
                    r_t              <= '0;
                    r_done           <= 1'b1;
                    if (r_last) begin
                        r_hash_valid <= 1'b1;
                    end
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
